seq_operand_sum: RTL

Parametrised successor to the two-register add-and-display datapath. It captures `NUM_CH` operands of `DATA_W` bits in one handshake, then presents each operand on `data_out`, one per cycle, zero-extended and tagged. It then presents their sum, or channel 0 minus the remaining channels, as a sign-extended `OUT_W` result. The block sits between the operand sources (switch or register front-end) and the display/readout logic, replacing the free-running 2-bit sequencer with a start/ready-controlled one.

---
 rtl/seq_operand_sum_pkg.sv | 25 ++
 rtl/seq_operand_sum_operand_bank.sv | 53 +++++
 rtl/seq_operand_sum.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seq_operand_sum_pkg.sv
// ---------------------------------------------------------------------------
// seq_operand_sum_pkg
//   Shared types and constants for the operand sequencer.
//   - state_t   : sequencer states (IDLE, SHOW, SUM)
//   - MODE_ADD  : sum all channels
//   - MODE_SUB  : channel 0 minus all remaining channels
//   - tag_width : width of the tag field needed to encode 0..num_ch
// ---------------------------------------------------------------------------
package seq_operand_sum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        SUM  = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // The tag must hold operand indices 0..num_ch-1 and the result marker num_ch.
    function automatic int tag_width(input int num_ch);
        return $clog2(num_ch + 1);
    endfunction

endpackage

// File: rtl/seq_operand_sum_operand_bank.sv
// ---------------------------------------------------------------------------
// operand_bank
//   NUM_CH x DATA_W register file. All channels load together from a packed
//   bus when load is high; a single read port selects one channel by index.
//   Ports:
//     Clock    : rising-edge clock
//     Reset    : synchronous, active-high; clears every channel
//     load     : capture all channels from data_in
//     data_in  : packed operands, channel k at [k*DATA_W +: DATA_W]
//     rd_idx   : channel to present on rd_data
//     rd_data  : selected channel (0 for an index past the last channel)
// ---------------------------------------------------------------------------
module operand_bank #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     load,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] regs [NUM_CH];

    // Capture every channel at once so a frame always sees one consistent
    // snapshot of the operand sources.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                regs[k] <= '0;
            end
        end else if (load) begin
            for (int k = 0; k < NUM_CH; k++) begin
                regs[k] <= data_in[k*DATA_W +: DATA_W];
            end
        end
    end

    // Compare-based read mux keeps non-power-of-two channel counts safe:
    // an index past the last channel simply reads zero.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_idx == IDX_W'(k)) begin
                rd_data = regs[k];
            end
        end
    end

endmodule

// File: rtl/seq_operand_sum.sv
// ---------------------------------------------------------------------------
// seq_operand_sum
//   Captures NUM_CH operands in one Start/Ready handshake, shows each operand
//   zero-extended (one per cycle, tagged with its index), then shows the sum
//   (Mode 0) or ch0 minus the remaining channels (Mode 1) at OUT_W bits.
//   Ports:
//     Clock     : rising-edge clock
//     Reset     : synchronous, active-high, priority over Start and Hold
//     Data_In   : packed operands, channel k at [k*DATA_W +: DATA_W]
//     Start     : frame request, accepted when Start & Ready
//     Mode      : 0 = add all, 1 = ch0 - rest; sampled with Start
//     Hold      : freezes sequencing while a frame is being shown
//     Ready     : block can accept Start
//     Out_Valid : data_out carries an operand or the result
//     Out_Last  : data_out carries the result
//     Out_Tag   : operand index, or NUM_CH for the result
//     data_out  : presented word
// ---------------------------------------------------------------------------
module seq_operand_sum
    import seq_operand_sum_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 2,
    parameter int OUT_W  = 16
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic [NUM_CH*DATA_W-1:0]         Data_In,
    input  logic                             Start,
    input  logic                             Mode,
    input  logic                             Hold,
    output logic                             Ready,
    output logic                             Out_Valid,
    output logic                             Out_Last,
    output logic [tag_width(NUM_CH)-1:0]     Out_Tag,
    output logic [OUT_W-1:0]                 data_out
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int TAG_W = tag_width(NUM_CH);

    generate
        if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
            $error("seq_operand_sum: NUM_CH must be in 2..8");
        end
        if (OUT_W < DATA_W + $clog2(NUM_CH) + 1) begin : g_bad_out_w
            $error("seq_operand_sum: OUT_W too narrow for DATA_W and NUM_CH");
        end
    endgenerate

    state_t             state, state_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic [OUT_W-1:0]   acc, acc_next;
    logic               mode_r, mode_next;
    logic               load;
    logic               accept;
    logic [DATA_W-1:0]  op_sel;
    logic [OUT_W-1:0]   op_ext;

    operand_bank #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_operand_bank (
        .Clock   (Clock),
        .Reset   (Reset),
        .load    (load),
        .data_in (Data_In),
        .rd_idx  (idx),
        .rd_data (op_sel)
    );

    assign op_ext = {{(OUT_W-DATA_W){1'b0}}, op_sel};

    // State register for the sequencer, index counter, accumulator and the
    // mode latched with the frame.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= IDLE;
            idx    <= '0;
            acc    <= '0;
            mode_r <= MODE_ADD;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            acc    <= acc_next;
            mode_r <= mode_next;
        end
    end

    // Next-state and output decode. Outputs depend only on registered state
    // and the operand bank; Hold is the one input allowed to gate Ready so
    // that a Start during a frozen result is refused rather than queued.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        acc_next   = acc;
        mode_next  = mode_r;
        load       = 1'b0;
        accept     = 1'b0;
        Ready      = 1'b0;
        Out_Valid  = 1'b0;
        Out_Last   = 1'b0;
        Out_Tag    = '0;
        data_out   = '0;

        case (state)
            IDLE: begin
                Ready  = 1'b1;
                accept = Start;
            end

            SHOW: begin
                Out_Valid = 1'b1;
                Out_Tag   = TAG_W'(idx);
                data_out  = op_ext;
                if (!Hold) begin
                    // Channel 0 seeds the accumulator; later channels fold in.
                    if (idx == '0) begin
                        acc_next = op_ext;
                    end else begin
                        case (mode_r)
                            MODE_ADD: acc_next = acc + op_ext;
                            MODE_SUB: acc_next = acc - op_ext;
                        endcase
                    end
                    if (idx == IDX_W'(NUM_CH - 1)) begin
                        state_next = SUM;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end

            SUM: begin
                Out_Valid = 1'b1;
                Out_Last  = 1'b1;
                Out_Tag   = TAG_W'(NUM_CH);
                data_out  = acc;
                if (!Hold) begin
                    Ready  = 1'b1;
                    accept = Start;
                    if (!Start) begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // A single reload path serves both a fresh frame from IDLE and a
        // back-to-back frame straight out of SUM.
        if (accept) begin
            load       = 1'b1;
            mode_next  = Mode;
            acc_next   = '0;
            idx_next   = '0;
            state_next = SHOW;
        end
    end

endmodule
